// File: rtl/traffic_light_monitor.sv
// Watches two lamp heads of a traffic light controller, times each phase and
// latches the first rule violation seen (lamp, conflict, sequence, timing).
module traffic_light_monitor #(
    parameter int GREEN_MAX  = 60,
    parameter int YELLOW_MIN = 3,
    parameter int YELLOW_MAX = 5,
    parameter int RED_MAX    = 99
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_tick,
    input  logic       i_clr,
    input  logic [2:0] i_led_a,
    input  logic [2:0] i_led_b,
    output logic [1:0] o_phase_a,
    output logic [1:0] o_phase_b,
    output logic       o_fault,
    output logic [2:0] o_fault_code,
    output logic       o_fault_dir,
    output logic [6:0] o_last_dur_a,
    output logic [6:0] o_last_dur_b,
    output logic [7:0] o_cycle_cnt
);

    typedef enum logic [1:0] {
        PH_INV = 2'b00,
        PH_RED = 2'b01,
        PH_YEL = 2'b10,
        PH_GRN = 2'b11
    } phase_t;

    function automatic phase_t decode(input logic [2:0] led);
        phase_t p;
        case (led)
            3'b001:  p = PH_RED;
            3'b010:  p = PH_YEL;
            3'b100:  p = PH_GRN;
            default: p = PH_INV;
        endcase
        return p;
    endfunction

    function automatic logic legal_step(input phase_t src, input phase_t dst);
        return (src == PH_RED && dst == PH_GRN) ||
               (src == PH_GRN && dst == PH_YEL) ||
               (src == PH_YEL && dst == PH_RED);
    endfunction

    // An invalid phase has no timing limit; the lamp fault covers it.
    function automatic int phase_max(input phase_t p);
        int m;
        case (p)
            PH_GRN:  m = GREEN_MAX;
            PH_YEL:  m = YELLOW_MAX;
            PH_RED:  m = RED_MAX;
            default: m = 128;
        endcase
        return m;
    endfunction

    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v == 7'd127) ? v : v + 7'd1;
    endfunction

    logic [2:0] led      [2];
    phase_t     ph       [2];
    phase_t     prev     [2];
    logic [6:0] dur      [2];
    logic [6:0] last_dur [2];
    logic [1:0] prev_vld;
    logic [1:0] change;
    logic [1:0] lamp_f;
    logic [1:0] trans_f;
    logic [1:0] over_f;
    logic [1:0] short_f;
    logic       conflict;
    logic       det_vld;
    logic [2:0] det_code;
    logic       det_dir;
    logic       fault_q;
    logic [2:0] code_q;
    logic       dir_q;
    logic [7:0] cycle_cnt;

    assign led[0] = i_led_a;
    assign led[1] = i_led_b;

    // Violations are judged on this cycle's lamps so they latch at the edge ending it.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            ph[d]      = decode(led[d]);
            change[d]  = i_en && prev_vld[d] && (ph[d] != prev[d]);
            lamp_f[d]  = i_en && (ph[d] == PH_INV);
            trans_f[d] = change[d] && !legal_step(prev[d], ph[d]);
            over_f[d]  = i_en && !change[d] && i_tick &&
                         (int'(dur[d]) >= phase_max(prev[d]));
            short_f[d] = change[d] && (prev[d] == PH_YEL) && (ph[d] == PH_RED) &&
                         (int'(dur[d]) < YELLOW_MIN);
        end
    end

    assign conflict = i_en && (ph[0] != PH_RED) && (ph[0] != PH_INV) &&
                      (ph[1] != PH_RED) && (ph[1] != PH_INV);

    always_comb begin
        det_vld  = 1'b0;
        det_code = 3'd0;
        det_dir  = 1'b0;
        if (lamp_f != 2'b00) begin
            det_vld  = 1'b1;
            det_code = 3'd1;
            det_dir  = !lamp_f[0];
        end else if (conflict) begin
            det_vld  = 1'b1;
            det_code = 3'd2;
        end else if (trans_f != 2'b00) begin
            det_vld  = 1'b1;
            det_code = 3'd3;
            det_dir  = !trans_f[0];
        end else if (over_f != 2'b00) begin
            det_vld  = 1'b1;
            det_code = 3'd4;
            det_dir  = !over_f[0];
        end else if (short_f != 2'b00) begin
            det_vld  = 1'b1;
            det_code = 3'd5;
            det_dir  = !short_f[0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int d = 0; d < 2; d++) begin
                prev[d]     <= PH_INV;
                dur[d]      <= '0;
                last_dur[d] <= '0;
            end
            prev_vld  <= '0;
            fault_q   <= 1'b0;
            code_q    <= 3'd0;
            dir_q     <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            prev_vld <= {2{i_en}};
            for (int d = 0; d < 2; d++) begin
                prev[d] <= ph[d];
                if (!i_en || change[d])
                    dur[d] <= '0;
                else if (i_tick)
                    dur[d] <= sat_inc(dur[d]);
                if (change[d])
                    last_dur[d] <= dur[d];
            end
            if (change[0] && prev[0] == PH_YEL && ph[0] == PH_RED)
                cycle_cnt <= cycle_cnt + 8'd1;
            if (i_clr) begin
                fault_q <= 1'b0;
                code_q  <= 3'd0;
                dir_q   <= 1'b0;
            end
            // A clear and a fresh violation in the same cycle leaves the new one latched.
            if (det_vld && (!fault_q || i_clr)) begin
                fault_q <= 1'b1;
                code_q  <= det_code;
                dir_q   <= det_dir;
            end
        end
    end

    assign o_phase_a    = prev[0];
    assign o_phase_b    = prev[1];
    assign o_fault      = fault_q;
    assign o_fault_code = code_q;
    assign o_fault_dir  = dir_q;
    assign o_last_dur_a = last_dur[0];
    assign o_last_dur_b = last_dur[1];
    assign o_cycle_cnt  = cycle_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a vector table for fault priority and
// clearing, plus hand-written sequences for timing, enable, wrap and reset cases.
module tb_traffic_light_monitor;

    localparam logic [2:0] LR = 3'b001;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b100;

    logic       clk = 1'b0;
    logic       rst, en, tick, clr;
    logic [2:0] led_a, led_b;
    logic [1:0] phase_a, phase_b;
    logic       fault;
    logic [2:0] fault_code;
    logic       fault_dir;
    logic [6:0] last_dur_a, last_dur_b;
    logic [7:0] cycle_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       clr;
        logic [2:0] a;
        logic [2:0] b;
        logic       f;
        logic [2:0] code;
        logic       dir;
        logic [1:0] pa;
        logic [1:0] pb;
    } vec_t;

    vec_t vt [14];

    traffic_light_monitor dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_tick       (tick),
        .i_clr        (clr),
        .i_led_a      (led_a),
        .i_led_b      (led_b),
        .o_phase_a    (phase_a),
        .o_phase_b    (phase_b),
        .o_fault      (fault),
        .o_fault_code (fault_code),
        .o_fault_dir  (fault_dir),
        .o_last_dur_a (last_dur_a),
        .o_last_dur_b (last_dur_b),
        .o_cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input logic e, input logic t, input logic c,
                       input logic [2:0] a, input logic [2:0] b);
        en = e; tick = t; clr = c; led_a = a; led_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_fault(input string name, input int f, input int c, input int d);
        chk({name, ".fault"}, fault, f);
        chk({name, ".code"}, fault_code, c);
        chk({name, ".dir"}, fault_dir, d);
    endtask

    // One full legal cycle of both heads: B cycles while A is red, then A cycles.
    task automatic full_loop();
        cyc(1, 0, 0, LR, LG);
        cyc(1, 0, 0, LR, LY);
        repeat (3) cyc(1, 1, 0, LR, LY);
        cyc(1, 0, 0, LR, LR);
        cyc(1, 0, 0, LG, LR);
        cyc(1, 0, 0, LY, LR);
        repeat (3) cyc(1, 1, 0, LY, LR);
        cyc(1, 0, 0, LR, LR);
    endtask

    initial begin
        vt[0]  = '{1'b0, LR,     3'b011, 1'b1, 3'd1, 1'b1, 2'b01, 2'b00};
        vt[1]  = '{1'b0, LR,     LR,     1'b1, 3'd1, 1'b1, 2'b01, 2'b01};
        vt[2]  = '{1'b1, LR,     LR,     1'b0, 3'd0, 1'b0, 2'b01, 2'b01};
        vt[3]  = '{1'b0, LG,     LR,     1'b0, 3'd0, 1'b0, 2'b11, 2'b01};
        vt[4]  = '{1'b0, LG,     3'b011, 1'b1, 3'd1, 1'b1, 2'b11, 2'b00};
        vt[5]  = '{1'b1, LG,     LY,     1'b1, 3'd2, 1'b0, 2'b11, 2'b10};
        vt[6]  = '{1'b0, LG,     LY,     1'b1, 3'd2, 1'b0, 2'b11, 2'b10};
        vt[7]  = '{1'b1, 3'b111, 3'b000, 1'b1, 3'd1, 1'b0, 2'b00, 2'b00};
        vt[8]  = '{1'b1, LR,     LR,     1'b1, 3'd3, 1'b0, 2'b01, 2'b01};
        vt[9]  = '{1'b1, LR,     LR,     1'b0, 3'd0, 1'b0, 2'b01, 2'b01};
        vt[10] = '{1'b0, LR,     LR,     1'b0, 3'd0, 1'b0, 2'b01, 2'b01};
        vt[11] = '{1'b0, LR,     3'b110, 1'b1, 3'd1, 1'b1, 2'b01, 2'b00};
        vt[12] = '{1'b1, LR,     LR,     1'b1, 3'd3, 1'b1, 2'b01, 2'b01};
        vt[13] = '{1'b1, LR,     LR,     1'b0, 3'd0, 1'b0, 2'b01, 2'b01};

        rst = 1'b1; en = 1'b0; tick = 1'b0; clr = 1'b0; led_a = LR; led_b = LR;
        repeat (2) @(posedge clk);
        #1;
        chk_fault("reset", 0, 0, 0);
        chk("reset.phase_a", phase_a, 0);
        chk("reset.phase_b", phase_b, 0);
        chk("reset.last_dur_a", last_dur_a, 0);
        chk("reset.last_dur_b", last_dur_b, 0);
        chk("reset.cycle_cnt", cycle_cnt, 0);
        rst = 1'b0;

        // Legal cycle: B green/yellow inside A red, then A green 20, yellow 3.
        cyc(1, 0, 0, LR, LG);
        repeat (4) cyc(1, 1, 0, LR, LG);
        cyc(1, 0, 0, LR, LY);
        chk("legal.last_dur_b_green", last_dur_b, 4);
        repeat (3) cyc(1, 1, 0, LR, LY);
        cyc(1, 0, 0, LR, LR);
        chk("legal.last_dur_b_yellow", last_dur_b, 3);
        repeat (3) cyc(1, 1, 0, LR, LR);
        cyc(1, 0, 0, LG, LR);
        chk("legal.last_dur_a_red", last_dur_a, 10);
        repeat (20) cyc(1, 1, 0, LG, LR);
        cyc(1, 0, 0, LY, LR);
        chk("legal.last_dur_a_green", last_dur_a, 20);
        repeat (3) cyc(1, 1, 0, LY, LR);
        cyc(1, 0, 0, LR, LR);
        chk("legal.last_dur_a_yellow", last_dur_a, 3);
        chk("legal.cycle_cnt", cycle_cnt, 1);
        chk_fault("legal", 0, 0, 0);
        chk("legal.phase_a", phase_a, 1);

        // Direct green to red, then a later lamp fault must not overwrite it.
        cyc(1, 0, 0, LG, LR);
        chk("illegal.pre_fault", fault, 0);
        cyc(1, 0, 0, LR, LR);
        chk_fault("illegal", 1, 3, 0);
        cyc(1, 0, 0, LR, 3'b011);
        chk_fault("illegal.held", 1, 3, 0);
        cyc(1, 0, 0, LR, LR);
        cyc(1, 0, 1, LR, LR);
        chk_fault("illegal.cleared", 0, 0, 0);
        chk("illegal.cycle_cnt", cycle_cnt, 1);

        for (int i = 0; i < 14; i++) begin
            cyc(1, 0, vt[i].clr, vt[i].a, vt[i].b);
            chk($sformatf("vec%0d.fault", i), fault, vt[i].f);
            chk($sformatf("vec%0d.code", i), fault_code, vt[i].code);
            chk($sformatf("vec%0d.dir", i), fault_dir, vt[i].dir);
            chk($sformatf("vec%0d.phase_a", i), phase_a, vt[i].pa);
            chk($sformatf("vec%0d.phase_b", i), phase_b, vt[i].pb);
        end

        // Yellow overrun on the sixth tick, then a short yellow.
        cyc(1, 0, 0, LG, LR);
        cyc(1, 0, 0, LY, LR);
        repeat (5) cyc(1, 1, 0, LY, LR);
        chk("overrun.before", fault, 0);
        cyc(1, 1, 0, LY, LR);
        chk_fault("overrun", 1, 4, 0);
        cyc(1, 0, 1, LR, LR);
        chk_fault("overrun.cleared", 0, 0, 0);
        chk("overrun.last_dur_a", last_dur_a, 6);
        chk("overrun.cycle_cnt", cycle_cnt, 2);
        cyc(1, 0, 0, LG, LR);
        cyc(1, 0, 0, LY, LR);
        repeat (2) cyc(1, 1, 0, LY, LR);
        cyc(1, 0, 0, LR, LR);
        chk_fault("short_yellow", 1, 5, 0);
        chk("short_yellow.last_dur_a", last_dur_a, 2);
        chk("short_yellow.cycle_cnt", cycle_cnt, 3);

        // Enable drops mid-green; nothing seen while disabled may fault.
        cyc(1, 0, 1, LR, LR);
        chk("enable.cleared", fault, 0);
        cyc(1, 0, 0, LG, LR);
        repeat (5) cyc(1, 1, 0, LG, LR);
        cyc(0, 1, 0, LG, LR);
        chk("enable.drop", fault, 0);
        cyc(0, 0, 0, 3'b000, LR);
        chk("enable.off_lamp", fault, 0);
        chk("enable.off_phase_a", phase_a, 0);
        cyc(0, 0, 0, LG, LY);
        chk("enable.off_conflict", fault, 0);
        cyc(0, 0, 0, LG, LR);
        cyc(1, 0, 0, LR, LR);
        chk("enable.reenable_red", fault, 0);
        repeat (3) cyc(1, 1, 0, LR, LR);
        cyc(1, 0, 0, LG, LR);
        chk("enable.last_dur_a", last_dur_a, 3);
        chk("enable.after", fault, 0);

        // Run the cycle counter up to its wrap.
        cyc(1, 0, 0, LY, LR);
        repeat (3) cyc(1, 1, 0, LY, LR);
        cyc(1, 0, 0, LR, LR);
        chk("wrap.start", cycle_cnt, 4);
        repeat (251) full_loop();
        chk("wrap.at_255", cycle_cnt, 255);
        chk("wrap.no_fault", fault, 0);
        chk("wrap.last_dur_b", last_dur_b, 3);
        full_loop();
        chk("wrap.to_0", cycle_cnt, 0);
        full_loop();
        chk("wrap.to_1", cycle_cnt, 1);

        // Reset while a fault is latched and the lamps are still bad.
        cyc(1, 0, 0, 3'b011, LR);
        chk_fault("rst_mid.fault", 1, 1, 0);
        rst = 1'b1;
        cyc(1, 0, 1, 3'b011, LR);
        rst = 1'b0;
        chk_fault("rst_mid", 0, 0, 0);
        chk("rst_mid.phase_b", phase_b, 0);
        chk("rst_mid.last_dur_a", last_dur_a, 0);
        chk("rst_mid.last_dur_b", last_dur_b, 0);
        chk("rst_mid.cycle_cnt", cycle_cnt, 0);
        cyc(1, 0, 0, LR, LR);
        chk("rst_mid.release_fault", fault, 0);
        chk("rst_mid.release_phase_a", phase_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
